id_ex_issue_stage: RTL and testbench
====================================

# id_ex_issue_stage

ID/EX issue stage directly upstream of the 64-bit ALU. It holds one decoded instruction in a valid/ready-handshaked pipeline register and translates the 2-bit main-decoder ALU op plus funct fields into the ALU's 4-bit operation code. It also resolves EX/MEM and MEM/WB forwarding and selects the immediate operand, presenting final `A`, `B` and `ALUOp` to the ALU. Its output feeds the ALU inputs and the EX/MEM register.

## Interface
Clock `clk`; reset `reset`, synchronous, active-high.

Parameters
- `XLEN`, default 64: datapath width.

Ports (`clk`/`reset` first)
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: kill the held and incoming instruction (branch/jump redirect).
- `in_valid` in 1: ID presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_rs1_data`, `in_rs2_data`, `in_imm` in XLEN: register-file reads and sign-extended immediate.
- `in_rs1`, `in_rs2`, `in_rd` in 5: register indices.
- `in_aluop` in 2: main-decoder class: 00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- `in_funct3` in 3: instruction funct3.
- `in_funct7_5` in 1: instruction bit 30.
- `in_alusrc` in 1: 1 selects the immediate as the B operand.
- `in_regwrite` in 1: instruction writes `rd`.
- `exm_regwrite` in 1, `exm_rd` in 5, `exm_result` in XLEN: EX/MEM forwarding source.
- `mwb_regwrite` in 1, `mwb_rd` in 5, `mwb_result` in XLEN: MEM/WB forwarding source.
- `out_valid` out 1: held instruction valid.
- `out_ready` in 1: EX/MEM accepts this cycle.
- `out_a`, `out_b` out XLEN: ALU operands.
- `out_alu_op` out 4: ALU operation code.
- `out_store_data` out XLEN: forwarded rs2 value.
- `out_rd` out 5: held destination index.
- `out_regwrite` out 1: held write enable.
- `out_illegal` out 1: held encoding had no ALU mapping.

## Operation
- Single-entry register. `in_ready = !out_valid || out_ready`. Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- On capture, latch all `in_*` fields and the decoded op; `out_valid` <= 1.
- On transfer out with no capture, `out_valid` <= 0. Simultaneous out and in: new instruction replaces the old one; `out_valid` stays 1.
- ALU-op decode is performed at capture and registered:
  - 00 -> 0010 (ADD).
  - 01 -> 0110 (SUB).
  - 10, by funct3/funct7_5:
    - 000/0 -> 0010.
    - 000/1 -> 0110.
    - 111/0 -> 0000.
    - 110/0 -> 0001.
  - 11, by funct3:
    - 000 -> 0010.
    - 001 with funct7_5 = 0 -> 1000 (SLLI).
    - 111 -> 0000.
    - 110 -> 0001.
  - Any other combination -> 0010 with `out_illegal` = 1.
- Forwarding is combinational from the held rs indices, so it tracks the sources while the stage is stalled:
  - If `exm_regwrite`, `exm_rd != 0` and `exm_rd == rs`, use `exm_result`.
  - Else if `mwb_regwrite`, `mwb_rd != 0` and `mwb_rd == rs`, use `mwb_result`.
  - Else use the latched register-file data.
  - EX/MEM has priority over MEM/WB. rs = 0 is never forwarded.
- `out_a` = forwarded rs1.
- `out_store_data` = forwarded rs2.
- `out_b` = latched imm if the held `alusrc` is 1, else forwarded rs2.
- `flush` next cycle: `out_valid` <= 0; a simultaneous input is discarded. `reset` beats `flush`.
- When `out_valid` = 0, `out_regwrite` reads 0 (gated).

## Timing
- Latency: 1 cycle from the capture edge to `out_valid`. `out_alu_op` is registered.
- `in_ready` is combinational from `out_valid`/`out_ready` (no registered stall), which allows full throughput of 1 instruction per cycle.
- Reset values:
  - `out_valid` = 0.
  - All latched fields = 0, so `out_alu_op` = 0000, `out_illegal` = 0, `out_rd` = 0, `out_regwrite` = 0.
  - `out_a` = `out_b` = `out_store_data` = 0, since rs = 0 suppresses forwarding.
  - `in_ready` = 1.
- Reset mid-stall drops the held instruction.
- Stalled (`out_valid` && `!out_ready`):
  - Latched fields are stable.
  - `out_a`/`out_b` may change only through forwarding sources.

## Test plan
- Reset, then `in_valid` with R-type add (aluop 10, f3 000, f7_5 0), rs1 data 5, rs2 data 7 -> next cycle `out_valid` = 1, `out_alu_op` = 0010, `out_a` = 5, `out_b` = 7.
- slli (aluop 11, f3 001, alusrc 1, imm 3) -> `out_alu_op` = 1000, `out_b` = 3. Same with f7_5 = 1 -> `out_alu_op` = 0010 and `out_illegal` = 1.
- Held rs1 = 4, with `exm_rd` = 4 / `exm_result` = 100 and `mwb_rd` = 4 / `mwb_result` = 200 both writing -> `out_a` = 100. Drop exm_regwrite -> `out_a` = 200. Set rs1 = 0 with matching rd 0 -> `out_a` = 0.
- `out_ready` = 0 for 3 cycles with `in_valid` = 1 -> `in_ready` = 0 and the held op is unchanged. Then `out_ready` = 1 -> the new instruction appears the following cycle with no bubble.
- `flush` asserted together with `in_valid` while holding a valid entry -> next cycle `out_valid` = 0 and `out_regwrite` = 0. Assert `reset` with `flush` -> all reset values.
- Back-to-back sub (f7_5 1), and (111), or (110) R-types with `out_ready` = 1 -> `out_alu_op` sequence 0110, 0000, 0001 on consecutive cycles.

Source files
------------

// File: rtl/id_ex_issue_stage.sv
// ID/EX issue stage: single-entry valid/ready register that decodes the ALU op at capture
// and resolves EX/MEM and MEM/WB forwarding combinationally from the held rs indices.

module id_ex_issue_fwd #(
    parameter int XLEN = 64
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exm_regwrite,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_regwrite,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] data
);
    always_comb begin
        data = rf_data;
        if (exm_regwrite && exm_rd != 5'd0 && exm_rd == rs)
            data = exm_result;
        else if (mwb_regwrite && mwb_rd != 5'd0 && mwb_rd == rs)
            data = mwb_result;
    end
endmodule

module id_ex_issue_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic            in_alusrc,
    input  logic            in_regwrite,
    input  logic            exm_regwrite,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_regwrite,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_op,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_illegal
);
    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            alusrc;
        logic            regwrite;
        logic            illegal;
    } entry_t;

    entry_t     held, nxt;
    logic       vld;
    logic [3:0] dec_op;
    logic       dec_ill;
    logic       cap, xfer_out;

    assign in_ready = !vld || out_ready;
    assign cap      = in_valid && in_ready;
    assign xfer_out = vld && out_ready;

    // Unmapped encodings still issue as ADD so the pipe keeps moving; illegal is flagged.
    always_comb begin
        dec_op  = 4'b0010;
        dec_ill = 1'b0;
        case (in_aluop)
            2'b00: dec_op = 4'b0010;
            2'b01: dec_op = 4'b0110;
            2'b10: begin
                case ({in_funct3, in_funct7_5})
                    4'b000_0: dec_op = 4'b0010;
                    4'b000_1: dec_op = 4'b0110;
                    4'b111_0: dec_op = 4'b0000;
                    4'b110_0: dec_op = 4'b0001;
                    default:  dec_ill = 1'b1;
                endcase
            end
            2'b11: begin
                case (in_funct3)
                    3'b000: dec_op = 4'b0010;
                    3'b001: begin
                        if (!in_funct7_5) dec_op = 4'b1000;
                        else              dec_ill = 1'b1;
                    end
                    3'b111: dec_op = 4'b0000;
                    3'b110: dec_op = 4'b0001;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        nxt.rs1_data = in_rs1_data;
        nxt.rs2_data = in_rs2_data;
        nxt.imm      = in_imm;
        nxt.rs1      = in_rs1;
        nxt.rs2      = in_rs2;
        nxt.rd       = in_rd;
        nxt.alu_op   = dec_op;
        nxt.alusrc   = in_alusrc;
        nxt.regwrite = in_regwrite;
        nxt.illegal  = dec_ill;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= 1'b0;
            held <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (cap) begin
            vld  <= 1'b1;
            held <= nxt;
        end else if (xfer_out) begin
            vld <= 1'b0;
        end
    end

    // Operand 0 is rs1, operand 1 is rs2.
    logic [1:0][4:0]      rs_idx;
    logic [1:0][XLEN-1:0] rf_data, fwd_data;

    assign rs_idx[0]  = held.rs1;
    assign rs_idx[1]  = held.rs2;
    assign rf_data[0] = held.rs1_data;
    assign rf_data[1] = held.rs2_data;

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        id_ex_issue_fwd #(.XLEN(XLEN)) u_fwd (
            .rs           (rs_idx[g]),
            .rf_data      (rf_data[g]),
            .exm_regwrite (exm_regwrite),
            .exm_rd       (exm_rd),
            .exm_result   (exm_result),
            .mwb_regwrite (mwb_regwrite),
            .mwb_rd       (mwb_rd),
            .mwb_result   (mwb_result),
            .data         (fwd_data[g])
        );
    end

    assign out_valid      = vld;
    assign out_a          = fwd_data[0];
    assign out_store_data = fwd_data[1];
    assign out_b          = held.alusrc ? held.imm : fwd_data[1];
    assign out_alu_op     = held.alu_op;
    assign out_rd         = held.rd;
    assign out_regwrite   = vld && held.regwrite;
    assign out_illegal    = held.illegal;
endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Scoreboard bench for id_ex_issue_stage: expected issue results are queued at drive time
// and popped when the stage presents them.

module tb_id_ex_issue_stage;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic [1:0]      in_aluop;
    logic [2:0]      in_funct3;
    logic            in_funct7_5, in_alusrc, in_regwrite;
    logic            exm_regwrite, mwb_regwrite;
    logic [4:0]      exm_rd, mwb_rd;
    logic [XLEN-1:0] exm_result, mwb_result;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_a, out_b, out_store_data;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd;
    logic            out_regwrite, out_illegal;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]      op;
        logic [XLEN-1:0] a, b;
        logic            ill;
        logic [4:0]      rd;
        logic            rw;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    id_ex_issue_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_aluop(in_aluop), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_alusrc(in_alusrc), .in_regwrite(in_regwrite),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
        .out_store_data(out_store_data), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction and queue what the stage should present for it (no forwarding).
    task automatic drive(input logic [1:0] aluop, input logic [2:0] f3, input logic f75,
                         input logic alusrc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [XLEN-1:0] d1,
                         input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                         input logic [3:0] eop, input logic eill);
        exp_t x;
        in_valid = 1'b1; in_aluop = aluop; in_funct3 = f3; in_funct7_5 = f75;
        in_alusrc = alusrc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_regwrite = 1'b1;
        x.op = eop; x.a = d1; x.b = alusrc ? imm : d2; x.ill = eill; x.rd = rd; x.rw = 1'b1;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (out_alu_op !== 4'b0000) begin n_fail++; $display("FAIL reset_op got %b want 0000", out_alu_op); end
        n_chk++; if ({out_illegal, out_regwrite, out_rd} !== 7'd0) begin n_fail++; $display("FAIL reset_fields got ill=%b rw=%b rd=%0d want 0", out_illegal, out_regwrite, out_rd); end
        n_chk++; if ({out_a, out_b, out_store_data} !== '0) begin n_fail++; $display("FAIL reset_data got a=%0h b=%0h sd=%0h want 0", out_a, out_b, out_store_data); end
    endtask

    task automatic test_rtype_add();
        drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd99, 4'b0010, 1'b0);
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", out_valid); end
        e = sb.pop_front();
        n_chk++; if (out_alu_op !== e.op || out_illegal !== e.ill) begin n_fail++; $display("FAIL add_op got %b/%b want %b/%b", out_alu_op, out_illegal, e.op, e.ill); end
        n_chk++; if (out_a !== e.a || out_b !== e.b) begin n_fail++; $display("FAIL add_ops got a=%0d b=%0d want a=%0d b=%0d", out_a, out_b, e.a, e.b); end
        n_chk++; if (out_rd !== e.rd || out_regwrite !== e.rw) begin n_fail++; $display("FAIL add_rd got %0d/%b want %0d/%b", out_rd, out_regwrite, e.rd, e.rw); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", out_valid); end
    endtask

    task automatic test_slli();
        drive(2'b11, 3'b001, 1'b0, 1'b1, 5'd6, 5'd0, 5'd7, 64'd9, 64'd0, 64'd3, 4'b1000, 1'b0);
        tick();
        e = sb.pop_front();
        n_chk++; if (out_alu_op !== e.op || out_b !== e.b || out_illegal !== e.ill) begin n_fail++; $display("FAIL slli got op=%b b=%0d ill=%b want op=%b b=%0d ill=%b", out_alu_op, out_b, out_illegal, e.op, e.b, e.ill); end
        drive(2'b11, 3'b001, 1'b1, 1'b1, 5'd6, 5'd0, 5'd7, 64'd9, 64'd0, 64'd3, 4'b0010, 1'b1);
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_chk++; if (out_alu_op !== e.op || out_illegal !== e.ill) begin n_fail++; $display("FAIL slli_f7 got op=%b ill=%b want op=%b ill=%b", out_alu_op, out_illegal, e.op, e.ill); end
        // A non-illegal I-type with f7_5 set (andi) must not be flagged
        drive(2'b11, 3'b111, 1'b1, 1'b1, 5'd6, 5'd0, 5'd7, 64'd9, 64'd0, 64'd3, 4'b0000, 1'b0);
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_chk++; if (out_alu_op !== e.op || out_illegal !== e.ill) begin n_fail++; $display("FAIL andi got op=%b ill=%b want op=%b ill=%b", out_alu_op, out_illegal, e.op, e.ill); end
        tick();
    endtask

    task automatic test_forward();
        out_ready = 1'b0;
        drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd4, 5'd5, 5'd8, 64'd11, 64'd22, 64'd0, 4'b0010, 1'b0);
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_chk++; if (out_a !== e.a) begin n_fail++; $display("FAIL fwd_none got %0d want %0d", out_a, e.a); end
        exm_regwrite = 1'b1; exm_rd = 5'd4; exm_result = 64'd100;
        mwb_regwrite = 1'b1; mwb_rd = 5'd4; mwb_result = 64'd200;
        #1;
        n_chk++; if (out_a !== 64'd100) begin n_fail++; $display("FAIL fwd_exm_prio got %0d want 100", out_a); end
        n_chk++; if (out_b !== 64'd22) begin n_fail++; $display("FAIL fwd_rs2_nomatch got %0d want 22", out_b); end
        exm_regwrite = 1'b0;
        #1;
        n_chk++; if (out_a !== 64'd200) begin n_fail++; $display("FAIL fwd_mwb got %0d want 200", out_a); end
        exm_regwrite = 1'b1; exm_rd = 5'd5;
        #1;
        n_chk++; if (out_b !== 64'd100 || out_store_data !== 64'd100) begin n_fail++; $display("FAIL fwd_rs2 got b=%0d sd=%0d want 100", out_b, out_store_data); end
        // Replace with an rs1 = 0 instruction while both sources claim rd 0
        out_ready = 1'b1;
        exm_rd = 5'd0; mwb_rd = 5'd0;
        drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 64'd0, 64'd0, 64'd0, 4'b0010, 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        e = sb.pop_front();
        n_chk++; if (out_a !== e.a || out_b !== e.b) begin n_fail++; $display("FAIL fwd_x0 got a=%0d b=%0d want a=%0d b=%0d", out_a, out_b, e.a, e.b); end
        exm_regwrite = 1'b0; mwb_regwrite = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        logic [3:0] held_op;
        drive(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 64'd1, 64'd2, 64'd0, 4'b0001, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd11, 64'd30, 64'd8, 64'd0, 4'b0110, 1'b0);
        e = sb.pop_front();
        held_op = e.op;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, in_ready); end
            n_chk++; if (out_alu_op !== held_op || out_rd !== e.rd || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc %0d got op=%b rd=%0d v=%b want op=%b rd=%0d v=1", i, out_alu_op, out_rd, out_valid, held_op, e.rd); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_chk++; if (out_valid !== 1'b1 || out_alu_op !== e.op || out_rd !== e.rd || out_a !== e.a) begin n_fail++; $display("FAIL stall_release got v=%b op=%b rd=%0d a=%0d want v=1 op=%b rd=%0d a=%0d", out_valid, out_alu_op, out_rd, out_a, e.op, e.rd, e.a); end
        tick();
    endtask

    task automatic test_flush();
        drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 5'd12, 64'd5, 64'd6, 64'd0, 4'b0010, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(2'b10, 3'b111, 1'b0, 1'b0, 5'd3, 5'd4, 5'd13, 64'd5, 64'd6, 64'd0, 4'b0000, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        n_chk++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0) begin n_fail++; $display("FAIL flush got v=%b rw=%b want 0/0", out_valid, out_regwrite); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", in_ready); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got v=%b want 0", out_valid); end
        // Reset together with flush over a held entry
        drive(2'b11, 3'b110, 1'b0, 1'b1, 5'd3, 5'd4, 5'd14, 64'd5, 64'd6, 64'd77, 4'b0001, 1'b0);
        tick();
        drive(2'b10, 3'b000, 1'b1, 1'b0, 5'd3, 5'd4, 5'd15, 64'd5, 64'd6, 64'd0, 4'b0110, 1'b0);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sb.delete();
        #1;
        n_chk++; if (out_valid !== 1'b0 || out_alu_op !== 4'b0000 || out_rd !== 5'd0 || out_regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_flush got v=%b op=%b rd=%0d rw=%b want all 0", out_valid, out_alu_op, out_rd, out_regwrite); end
        n_chk++; if (out_a !== '0 || out_b !== '0 || out_store_data !== '0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_flush_data got a=%0h b=%0h sd=%0h rdy=%b want 0/0/0/1", out_a, out_b, out_store_data, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3s [3];
        logic       f7s [3];
        logic [3:0] ops [3];
        f3s = '{3'b000, 3'b111, 3'b110};
        f7s = '{1'b1, 1'b0, 1'b0};
        ops = '{4'b0110, 4'b0000, 4'b0001};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, f3s[i], f7s[i], 1'b0, 5'd1, 5'd2, 5'(16 + i), 64'(i + 40), 64'(i + 50), 64'd0, ops[i], 1'b0);
            tick();
            if (i == 2) in_valid = 1'b0;
            if (sb.size() == 0) begin
                n_chk++; n_fail++; $display("FAIL b2b_sb_empty cyc %0d got 0 entries want 1", i);
            end else begin
                e = sb.pop_front();
                n_chk++; if (out_valid !== 1'b1 || out_alu_op !== e.op || out_rd !== e.rd || out_a !== e.a) begin n_fail++; $display("FAIL b2b cyc %0d got v=%b op=%b rd=%0d a=%0d want v=1 op=%b rd=%0d a=%0d", i, out_valid, out_alu_op, out_rd, out_a, e.op, e.rd, e.a); end
            end
        end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_aluop = '0; in_funct3 = '0; in_funct7_5 = 1'b0; in_alusrc = 1'b0; in_regwrite = 1'b0;
        exm_regwrite = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_regwrite = 1'b0; mwb_rd = '0; mwb_result = '0;
        test_reset();
        test_rtype_add();
        test_slli();
        test_forward();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
